// File: rtl/lock_ctrl_pkg.sv
// Shared definitions for the keypad lock: key codes, controller states and
// the factory default code.
package lock_ctrl_pkg;

  localparam int KEY_W  = 4;
  localparam int DIGITS = 4;
  localparam int CODE_W = KEY_W * DIGITS;

  localparam logic [KEY_W-1:0] KEY_ENTER  = 4'd10;
  localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'd11;
  localparam logic [KEY_W-1:0] KEY_CHANGE = 4'd12;

  localparam logic [KEY_W-1:0]  DEFAULT_DIGIT = 4'd6;
  localparam logic [CODE_W-1:0] DEFAULT_CODE  = {DIGITS{DEFAULT_DIGIT}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT,
    ST_NEW_PW,
    ST_CONFIRM
  } lock_state_t;

  // Digit keys are 0-9; everything above is a command or reserved.
  function automatic logic isDigitKey(input logic [KEY_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad-side bundle: key strobe in, lock status out.
interface lock_ctrl_if;
  import lock_ctrl_pkg::*;

  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             unlocked;
  logic             alarm;
  logic             pw_changed;
  logic [2:0]       digit_cnt;
  logic [1:0]       err_cnt;
  logic             chg_mode;

  modport master (
    output key_valid, key_code,
    input  unlocked, alarm, pw_changed, digit_cnt, err_cnt, chg_mode
  );

  modport slave (
    input  key_valid, key_code,
    output unlocked, alarm, pw_changed, digit_cnt, err_cnt, chg_mode
  );

endinterface

// File: rtl/lock_keybuf.sv
// Four-digit entry buffer. New digits enter at position 0 and older ones move
// up; once four digits are held further digits are dropped. Clear wins over
// a simultaneous shift. match_o compares a full buffer against ref_i.
module lock_keybuf
  import lock_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [KEY_W-1:0]  digit_i,
  input  logic [CODE_W-1:0] ref_i,
  output logic [CODE_W-1:0] digits_o,
  output logic [2:0]        cnt_o,
  output logic              match_o
);

  logic [CODE_W-1:0] digits_q, digits_d;
  logic [2:0]        cnt_q, cnt_d;

  // Next buffer contents: clear, shift a digit in, or hold.
  always_comb begin
    digits_d = digits_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      digits_d = '0;
      cnt_d    = 3'd0;
    end else if (shift_i && (cnt_q < 3'd4)) begin
      digits_d = {digits_q[CODE_W-KEY_W-1:0], digit_i};
      cnt_d    = cnt_q + 3'd1;
    end
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digits_q <= '0;
      cnt_q    <= 3'd0;
    end else begin
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
    end
  end

  assign digits_o = digits_q;
  assign cnt_o    = cnt_q;
  assign match_o  = (cnt_q == 3'd4) && (digits_q == ref_i);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code check, timed unlock, lockout after repeated
// failures and a two-step (enter + confirm) code change reachable only while
// the lock is open.
module lock_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        reset,
  lock_ctrl_if.slave kp
);

  localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  lock_state_t       state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        errCnt_q, errCnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] storedKey_q, storedKey_d;
  logic              unlocked_q, alarm_q, pwChanged_q, chgMode_q;

  logic              keyLive;
  logic              isDigit, isEnter, isClear, isChange;
  logic              bufClear, bufShift, bufMatch, commit;
  logic [CODE_W-1:0] bufDigits, bufRef;
  logic [2:0]        bufCnt;
  logic [2:0]        errInc;

  // In CONFIRM the buffer is checked against the candidate, otherwise against the stored key.
  assign bufRef = (state_q == ST_CONFIRM) ? cand_q : storedKey_q;
  assign errInc = {1'b0, errCnt_q} + 3'd1;

  lock_keybuf u_keybuf (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bufClear),
    .shift_i  (bufShift),
    .digit_i  (kp.key_code),
    .ref_i    (bufRef),
    .digits_o (bufDigits),
    .cnt_o    (bufCnt),
    .match_o  (bufMatch)
  );

  // Next-state, timer, error count and buffer control for every controller state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    errCnt_d    = errCnt_q;
    cand_d      = cand_q;
    storedKey_d = storedKey_q;
    bufClear    = 1'b0;
    bufShift    = 1'b0;
    commit      = 1'b0;

    keyLive  = kp.key_valid && (state_q inside {ST_IDLE, ST_OPEN, ST_NEW_PW, ST_CONFIRM});
    isDigit  = keyLive && isDigitKey(kp.key_code);
    isEnter  = keyLive && (kp.key_code == KEY_ENTER);
    isClear  = keyLive && (kp.key_code == KEY_CLEAR);
    isChange = keyLive && (kp.key_code == KEY_CHANGE);

    bufShift = isDigit;
    bufClear = isClear;

    case (state_q)
      ST_IDLE: begin
        if (isEnter) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        bufClear = 1'b1;
        if (bufMatch) begin
          state_d  = ST_OPEN;
          timer_d  = TW'(UNLOCK_CYCLES - 1);
          errCnt_d = 2'd0;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        if (errInc == 3'(MAX_TRIES)) begin
          state_d = ST_LOCKOUT;
          timer_d = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d  = ST_IDLE;
          errCnt_d = errInc[1:0];
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d  = ST_IDLE;
          errCnt_d = 2'd0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_OPEN: begin
        if (isChange) begin
          state_d  = ST_NEW_PW;
          timer_d  = '0;
          bufClear = 1'b1;
        end else if (timer_q == '0) begin
          state_d  = ST_IDLE;
          bufClear = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_NEW_PW: begin
        if (isEnter) begin
          bufClear = 1'b1;
          if (bufCnt == 3'd4) begin
            cand_d  = bufDigits;
            state_d = ST_CONFIRM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CONFIRM: begin
        if (isEnter) begin
          bufClear = 1'b1;
          state_d  = ST_IDLE;
          if (bufMatch) begin
            storedKey_d = cand_q;
            commit      = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; status outputs are registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      errCnt_q    <= 2'd0;
      cand_q      <= DEFAULT_CODE;
      storedKey_q <= DEFAULT_CODE;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
      pwChanged_q <= 1'b0;
      chgMode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      errCnt_q    <= errCnt_d;
      cand_q      <= cand_d;
      storedKey_q <= storedKey_d;
      unlocked_q  <= (state_d == ST_OPEN);
      alarm_q     <= (state_d == ST_LOCKOUT);
      pwChanged_q <= commit;
      chgMode_q   <= (state_d == ST_NEW_PW) || (state_d == ST_CONFIRM);
    end
  end

  assign kp.unlocked   = unlocked_q;
  assign kp.alarm      = alarm_q;
  assign kp.pw_changed = pwChanged_q;
  assign kp.digit_cnt  = bufCnt;
  assign kp.err_cnt    = errCnt_q;
  assign kp.chg_mode   = chgMode_q;

endmodule
